serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around the team's existing one-bit full-adder cell (FullAdd).
- Accepts two WIDTH-bit operands and a carry-in on a start pulse.
- Feeds the full-adder one bit per clock, LSB first, and keeps the carry in a flip-flop between bits.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequential stage that directly drives the full-adder cell.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 2..32)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only when not busy
a      input   WIDTH  operand A, captured on accepted start
b      input   WIDTH  operand B, captured on accepted start
cin    input   1      carry-in, captured on accepted start
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse: sum/cout valid
sum    output  WIDTH  result; holds until next done
cout   output  1      final carry; holds until next done

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, bit counter=0, shift registers=0.
- Reset release: the first active edge after rst_n rises may accept start.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per edge.
  - DONE: one cycle; done=1.
- IDLE/DONE + start=1 on an edge:
  - Capture a and b into shift registers and cin into the carry FF.
  - Clear the counter and go to RUN.
- RUN, each edge:
  - Full-adder inputs are a_sh[0], b_sh[0] and carry.
  - The sum bit shifts into a working register at the MSB end.
  - a_sh and b_sh shift right by one.
  - Carry FF takes the full-adder carry-out.
  - Counter increments.
- RUN, edge where counter==WIDTH-1: after that bit is processed, load sum from the completed working register and cout from the final carry, then go to DONE.
- DONE lasts one cycle, then returns to IDLE. start=1 during DONE is accepted exactly as in IDLE, giving back-to-back operations with no idle gap.
- Latency: done is high during the cycle following the WIDTH-th edge after the edge that accepted start (WIDTH=8: 8 edges).
- Throughput: one result per WIDTH+1 cycles back-to-back.
- busy = (state==RUN). It rises on the accepting edge and falls on the same edge done rises.
- start while busy: ignored; operands are not re-captured and the running operation is unaffected.
- sum/cout change only on the edge entering DONE. They are stable through RUN of a following operation (the old result stays visible).
- Arithmetic: {cout,sum} = a + b + cin, exact, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-operation: aborts immediately, with all outputs as in reset. No done pulse is produced for the aborted operation.
- Inputs a, b and cin are don't-care outside the accepting edge.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2); counter width constant CNT_W = clog2(WIDTH).
- One sub-module: a single instance of the existing one-bit full-adder cell (FullAdd) for per-bit arithmetic; no other hierarchy.
- Everything else (shift registers, carry FF, counter, FSM) is inline.

Test Plan:
- Basic add: WIDTH=8, a=8'h3C, b=8'h45, cin=0, start 1 cycle -> after 8 edges done=1 for one cycle, sum=8'h81, cout=0; busy high exactly 8 cycles.
- Carry propagation: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start while busy: start with a=8'h10, b=8'h20; reassert start with a=8'hAA, b=8'h55 at edge 3 of RUN -> one done only, sum=8'h30, cout=0, with timing unchanged.
- Back-to-back: hold start=1 with new operands a=8'h01, b=8'h02 during the done cycle of the previous op -> second done exactly 9 cycles after the first, sum=8'h03. Between the two dones, sum still shows the first result.
- Reset mid-op: start a=8'h80, b=8'h80; drop rst_n asynchronously at RUN edge 4 -> busy, done, sum and cout go 0 immediately with no clock. After release, a new start a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1.
- Random regression: 1000 random a/b/cin with random start gaps -> {cout,sum} matches a+b+cin. done count equals the number of accepted starts.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter width: clog2(WIDTH), never below one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell (FullAdd), the per-bit arithmetic of the serial adder.
module FullAdd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Plain sum/majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first,
// carry held in a flop between bits; result presented with a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, wrk;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] wrk_nxt;

  FullAdd u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  always_comb begin
    wrk_nxt = {fa_s, wrk[WIDTH-1:1]};
  end

  // Status flags are pure state decodes, so reset clears them immediately.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // FSM plus datapath: capture on accepted start, shift one bit per RUN edge,
  // publish sum/cout only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      wrk   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          wrk   <= wrk_nxt;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= wrk_nxt;
            cout  <= fa_co;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
